// File: rtl/lsu_if.sv
// Request/response handshake and data-memory lane bus for the load/store unit.
// The slave modport is the LSU's view; master is the CPU/memory environment view.
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_we;
  logic [31:0] dmem_wr_data;
  logic [31:0] dmem_rd_data;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, dmem_rd_data,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, dmem_addr, dmem_we, dmem_wr_data
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, dmem_rd_data,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, dmem_addr, dmem_we, dmem_wr_data
  );
endinterface

// File: rtl/lsu.sv
// RV32I load/store unit: drives four byte-lane memories with synchronous read,
// returns aligned and extended load data one cycle after the read completes.
module lsu #(
  parameter int ADDR_W = 11
) (
  input  logic clk,
  input  logic rst_n,
  lsu_if.slave bus
);

  typedef enum logic {IDLE, LOAD_WAIT} state_t;

  state_t      state_q, state_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  logic [2:0]  f3;
  logic [1:0]  off;
  logic        accept, illegal, misal, req_err;
  logic [3:0]  lane_we;
  logic [31:0] wr_data, load_fmt;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign f3     = bus.req_funct3;
  assign off    = bus.req_addr[1:0];
  assign accept = bus.req_valid && bus.req_ready;

  // Bits above ADDR_W are not decoded by the memory but still pass through.
  assign bus.dmem_addr = {bus.req_addr[31:ADDR_W], bus.req_addr[ADDR_W-1:0]};

  always_comb begin
    illegal = (f3 == 3'd3) || (f3[2:1] == 2'b11) || (f3[2] && bus.req_we);
    misal   = ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
    req_err = illegal || misal;
  end

  always_comb begin
    wr_data = bus.req_wdata;
    lane_we = 4'b1111;
    case (f3[1:0])
      2'b00: begin
        wr_data = {4{bus.req_wdata[7:0]}};
        lane_we = 4'b0001 << off;
      end
      2'b01: begin
        wr_data = {2{bus.req_wdata[15:0]}};
        lane_we = off[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  assign bus.dmem_wr_data = wr_data;
  assign bus.dmem_we      = (accept && bus.req_we && !req_err) ? lane_we : 4'b0000;

  always_comb begin
    ld_byte = bus.dmem_rd_data[8*off_q +: 8];
    ld_half = off_q[1] ? bus.dmem_rd_data[31:16] : bus.dmem_rd_data[15:0];
    case (f3_q)
      3'd0:    load_fmt = {{24{ld_byte[7]}}, ld_byte};
      3'd4:    load_fmt = {24'd0, ld_byte};
      3'd1:    load_fmt = {{16{ld_half[15]}}, ld_half};
      3'd5:    load_fmt = {16'd0, ld_half};
      default: load_fmt = bus.dmem_rd_data;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    f3_d          = f3_q;
    off_d         = off_q;
    bus.req_ready = 1'b0;
    rsp_valid_d   = 1'b0;
    rsp_err_d     = 1'b0;
    rsp_rdata_d   = 32'd0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (accept) begin
          if (req_err || bus.req_we) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = req_err;
          end else begin
            f3_d    = f3;
            off_d   = off;
            state_d = LOAD_WAIT;
          end
        end
      end
      LOAD_WAIT: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = load_fmt;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      f3_q        <= 3'd0;
      off_q       <= 2'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: stimulus pushes hand-computed responses, a monitor
// pops and compares them (data, error, latency) on every rsp_valid.
module tb_lsu;
  localparam int ADDR_W = 11;
  localparam int WORDS  = 1 << (ADDR_W - 2);

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          acc_cyc;
    int          lat;
  } exp_t;

  logic clk, rst_n;
  int   cyc;
  int   tests, fails;
  exp_t sb_q[$];

  lsu_if bus ();

  lsu #(.ADDR_W(ADDR_W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Byte-lane data memory with one-cycle synchronous read.
  logic [7:0]  mem [4][WORDS];
  logic [31:0] rd_q;
  logic [ADDR_W-3:0] widx;
  assign widx = bus.dmem_addr[ADDR_W-1:2];
  assign bus.dmem_rd_data = rd_q;

  always @(posedge clk) begin
    rd_q <= {mem[3][widx], mem[2][widx], mem[1][widx], mem[0][widx]};
    for (int l = 0; l < 4; l++)
      if (bus.dmem_we[l]) mem[l][widx] <= bus.dmem_wr_data[8*l +: 8];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 want no response (cyc %0d)", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
        chk("rsp_rdata", bus.rsp_rdata, e.rdata);
        chk("rsp_latency", cyc - e.acc_cyc, e.lat);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic xerr, input logic [31:0] xrd,
                       input logic [3:0] xwe, input logic chk_wd, input logic [31:0] xwd,
                       input bit hold, output int acc);
    int   waited;
    exp_t e;
    acc = -1;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    #1;
    waited = 0;
    while (bus.req_ready !== 1'b1 && waited < 8) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (bus.req_ready !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got req_ready=%b want 1", bus.req_ready);
      bus.req_valid = 1'b0;
      return;
    end
    chk("dmem_we", {28'd0, bus.dmem_we}, {28'd0, xwe});
    chk("dmem_addr", bus.dmem_addr, addr);
    if (chk_wd) chk("dmem_wr_data", bus.dmem_wr_data, xwd);
    acc     = cyc;
    e.err   = xerr;
    e.rdata = xrd;
    e.acc_cyc = cyc;
    e.lat   = (!we && !xerr) ? 2 : 1;
    sb_q.push_back(e);
    @(negedge clk);
    if (!hold) bus.req_valid = 1'b0;
    #1;
    chk("ready_after", {31'd0, bus.req_ready}, {31'd0, (we || xerr)});
  endtask

  int a0, a1, a2, a3, a4, d;

  initial begin
    tests = 0;
    fails = 0;
    cyc   = 0;
    for (int w = 0; w < WORDS; w++)
      for (int l = 0; l < 4; l++) mem[l][w] = 8'h00;
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("reset_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    chk("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("reset_req_ready", {31'd0, bus.req_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset while a load waits for memory: the load must vanish.
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd2;
    bus.req_addr   = 32'h10;
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midload_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("midload_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("midload_rsp_rdata", bus.rsp_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Byte
    issue(1, 3'd0, 32'h102, 32'h000000A5, 0, 32'h0, 4'b0100, 1, 32'hA5A5A5A5, 0, d);
    issue(0, 3'd0, 32'h102, 32'h0, 0, 32'hFFFFFFA5, 4'b0000, 0, 32'h0, 0, d);
    issue(0, 3'd4, 32'h102, 32'h0, 0, 32'h000000A5, 4'b0000, 0, 32'h0, 0, d);
    issue(0, 3'd4, 32'h103, 32'h0, 0, 32'h00000000, 4'b0000, 0, 32'h0, 0, d);
    // Halfword
    issue(1, 3'd1, 32'h006, 32'h00008001, 0, 32'h0, 4'b1100, 1, 32'h80018001, 0, d);
    issue(0, 3'd1, 32'h006, 32'h0, 0, 32'hFFFF8001, 4'b0000, 0, 32'h0, 0, d);
    issue(0, 3'd5, 32'h006, 32'h0, 0, 32'h00008001, 4'b0000, 0, 32'h0, 0, d);
    // Word
    issue(1, 3'd2, 32'h010, 32'hDEADBEEF, 0, 32'h0, 4'b1111, 1, 32'hDEADBEEF, 0, d);
    issue(0, 3'd2, 32'h010, 32'h0, 0, 32'hDEADBEEF, 4'b0000, 0, 32'h0, 0, d);
    // Errors, then confirm memory untouched
    issue(1, 3'd2, 32'h013, 32'h12345678, 1, 32'h0, 4'b0000, 0, 32'h0, 0, d);
    issue(0, 3'd1, 32'h001, 32'h0, 1, 32'h0, 4'b0000, 0, 32'h0, 0, d);
    issue(0, 3'd3, 32'h000, 32'h0, 1, 32'h0, 4'b0000, 0, 32'h0, 0, d);
    issue(1, 3'd4, 32'h010, 32'h000000FF, 1, 32'h0, 4'b0000, 0, 32'h0, 0, d);
    issue(0, 3'd2, 32'h010, 32'h0, 0, 32'hDEADBEEF, 4'b0000, 0, 32'h0, 0, d);
    // Throughput with req_valid held high
    issue(1, 3'd0, 32'h020, 32'h00000011, 0, 32'h0, 4'b0001, 1, 32'h11111111, 1, a0);
    issue(1, 3'd1, 32'h022, 32'h00002233, 0, 32'h0, 4'b1100, 1, 32'h22332233, 1, a1);
    issue(1, 3'd2, 32'h024, 32'h44556677, 0, 32'h0, 4'b1111, 1, 32'h44556677, 1, a2);
    issue(0, 3'd2, 32'h020, 32'h0, 0, 32'h22330011, 4'b0000, 0, 32'h0, 1, a3);
    issue(0, 3'd2, 32'h024, 32'h0, 0, 32'h44556677, 4'b0000, 0, 32'h0, 0, a4);
    chk("tp_store1_gap", a1 - a0, 1);
    chk("tp_store2_gap", a2 - a1, 1);
    chk("tp_load1_gap", a3 - a2, 1);
    chk("tp_load2_gap", a4 - a3, 2);

    repeat (4) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
